// File: rtl/approx_eval_pkg.sv
// rtl/approx_eval_pkg.sv - shared types and width helpers for approximate-multiplier evaluation
package approx_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } eval_state_t;

    // Products of two WIDTH-bit operands are twice as wide.
    localparam int PROD_SCALE = 2;

    function automatic int prod_width(input int width);
        return PROD_SCALE * width;
    endfunction

    // Absolute-error accumulator: N samples of at most 2^(2W)-1 each.
    function automatic int acc_width(input int width, input int win_log2);
        return win_log2 + prod_width(width);
    endfunction

endpackage

// File: rtl/err_diff_stage.sv
// rtl/err_diff_stage.sv - registered exact multiply (S1) and signed/absolute error (S2)
module err_diff_stage
    import approx_eval_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int PW = prod_width(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 accept,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic [PW-1:0]        z_apx,
    output logic                 s1_valid,
    output logic signed [PW:0]   err,
    output logic [PW-1:0]        abs_err
);

    logic [PW-1:0] exact_q;
    logic [PW-1:0] z_q;

    // S1: capture the exact product and the approximate one for each accepted sample
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            exact_q  <= '0;
            z_q      <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                exact_q <= PW'(x) * PW'(y);
                z_q     <= z_apx;
            end
        end
    end

    // S2: one extra bit keeps the difference exact; its magnitude always fits PW bits
    always_comb begin
        err     = $signed({1'b0, z_q}) - $signed({1'b0, exact_q});
        abs_err = err[PW] ? PW'(-err) : err[PW-1:0];
    end

endmodule

// File: rtl/approx_mult_error_monitor.sv
// rtl/approx_mult_error_monitor.sv - windowed error statistics for an approximate multiplier
module approx_mult_error_monitor
    import approx_eval_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int WIN_LOG2 = 8,
    localparam int PW      = prod_width(WIDTH),
    localparam int ACC_W   = acc_width(WIDTH, WIN_LOG2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic [PW-1:0]        z_apx,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WIN_LOG2:0]    err_count,
    output logic [ACC_W-1:0]     sae,
    output logic [ACC_W:0]       sse,
    output logic [PW-1:0]        max_err,
    output logic                 busy
);

    eval_state_t state, state_next;
    logic [WIN_LOG2-1:0] sample_cnt;
    logic accept;
    logic last_accept;
    logic clear;
    logic s1_valid;
    logic signed [PW:0] err;
    logic [PW-1:0] abs_err;

    assign accept      = in_valid && (state == RUN);
    assign last_accept = accept && (&sample_cnt);
    assign busy        = (state != IDLE);

    err_diff_stage #(.WIDTH(WIDTH)) u_diff (
        .clk      (clk),
        .rst      (rst),
        .accept   (accept),
        .x        (x),
        .y        (y),
        .z_apx    (z_apx),
        .s1_valid (s1_valid),
        .err      (err),
        .abs_err  (abs_err)
    );

    // Window sequencing: the accumulator update is the S2 register, so S1 empty means drained
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        res_valid  = 1'b0;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                if (last_accept) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1_valid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sample counter; wraps to zero on the final accept of the window
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sample_cnt <= '0;
        end else if (accept) begin
            sample_cnt <= sample_cnt + 1'b1;
        end
    end

    // Statistics accumulate one sample per S2 beat; widths are sized so nothing can wrap
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            err_count <= '0;
            sae       <= '0;
            sse       <= '0;
            max_err   <= '0;
        end else if (s1_valid) begin
            err_count <= err_count + {{WIN_LOG2{1'b0}}, (|abs_err)};
            sae       <= sae + {{WIN_LOG2{1'b0}}, abs_err};
            sse       <= sse + {{WIN_LOG2{err[PW]}}, err};
            if (abs_err > max_err) begin
                max_err <= abs_err;
            end
        end
    end

endmodule

// File: doc/approx_mult_error_monitor.md
Name: approx_mult_error_monitor

Overview:
- Downstream characterisation stage for the team's 8x8 unsigned approximate multipliers.
- Each sample carries the operands x, y and the approximate product z_apx from the multiplier under test. The block computes the exact product internally.
- Over a window of 2^WIN_LOG2 samples it accumulates error statistics: error count, sum of absolute error, signed error sum and maximum absolute error. It then presents them on a valid/ready result port.
- Used in both the on-chip evaluation harness and the simulation harness to compute MED/ER/bias for each multiplier variant.

Parameters:
- WIDTH, 8, operand width; products are 2*WIDTH bits.
- WIN_LOG2, 8, log2 of samples per window (window N = 2^WIN_LOG2).
- ACC_W, WIN_LOG2+2*WIDTH, width of the absolute-error accumulator (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle pulse; begins a window. Honoured only in IDLE.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accepted when in_valid & in_ready.
- x  in  WIDTH  multiplicand.
- y  in  WIDTH  multiplier.
- z_apx  in  2*WIDTH  approximate product under test.
- res_valid  out  1  window statistics valid.
- res_ready  in  1  consumer accepts statistics.
- err_count  out  WIN_LOG2+1  number of samples with z_apx != x*y.
- sae  out  ACC_W  sum of |z_apx - x*y|.
- sse  out  ACC_W+1  signed sum of (z_apx - x*y), two's complement.
- max_err  out  2*WIDTH  maximum |z_apx - x*y| in the window.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE; in_ready=0, res_valid=0, busy=0; all statistics, the sample counter and the pipeline valids are 0.
  - Reset asserted mid-window abandons the window. No result is produced.
- State machine: IDLE, RUN, DRAIN, DONE.
  - IDLE: in_ready=0. On start, clear all accumulators, max_err and the sample counter, then go to RUN. Statistics outputs hold their previous window's values until this clear.
  - RUN: in_ready=1. Each handshake increments the sample counter. When the accepting handshake is sample N-1, in_ready drops the next cycle and the state goes to DRAIN. in_valid gaps are allowed and only stall counting.
  - DRAIN: in_ready=0. Wait until both pipeline stages are empty (exactly 2 cycles after the last accept), then go to DONE.
  - DONE: res_valid=1, outputs stable. On res_valid & res_ready go to IDLE, with res_valid=0 the next cycle.
  - start outside IDLE is ignored. start and res_ready in the same DONE cycle: return to IDLE only; start is not captured.
- Pipeline: 2 stages, each with its own valid bit.
  - S1 registers exact = x*y (2*WIDTH bits unsigned) and z_apx.
  - S2 computes e = z_apx - exact as a (2*WIDTH+1)-bit signed value, and a = |e| as 2*WIDTH bits (max 2^(2*WIDTH)-1, no overflow).
  - S2 updates: sae += a; sse += sign-extended e; err_count += (a!=0); max_err = max(max_err, a).
- Latency: a sample's effect is visible in the accumulators 2 cycles after its handshake. res_valid rises no earlier than 3 cycles after the last handshake.
- Width rules:
  - sae cannot overflow: N*(2^(2W)-1) < 2^ACC_W.
  - sse range is ±N*(2^(2W)-1), which fits ACC_W+1 signed.
  - err_count max N needs WIN_LOG2+1 bits.
  - No saturation logic is required.

Decomposition:
- Shared package approx_eval_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - localparam function for ACC_W;
  - product-width constant 2*WIDTH.
- One sub-module, err_diff_stage: the registered S1 exact-multiply plus S2 signed-diff/abs computation, with valid pass-through.
- Accumulators and FSM stay in the top.

Test Plan (WIN_LOG2=2, N=4, unless noted):
- Exact samples: z_apx=x*y for (3,5),(255,255),(0,9),(17,1) → err_count=0, sae=0, sse=0, max_err=0, res_valid after 3 cycles past the last accept.
- Over-estimate: z_apx=x*y+3 for all 4 samples → err_count=4, sae=12, sse=+12, max_err=3. Mixed: errors +5,-2,0,-7 → err_count=3, sae=14, sse=-4, max_err=7.
- Worst case, WIN_LOG2=8: x=y=255, z_apx=0 for all 256 samples → sae=16646400, sse=-16646400, err_count=256, max_err=65025; no wrap.
- Handshake gaps and backpressure:
  - in_valid toggled randomly → exactly 4 samples accepted, in_ready=0 in DRAIN/DONE.
  - res_ready held low 10 cycles → res_valid and all outputs stable; start pulsed in DONE is ignored.
- Reset and restart:
  - rst asserted after 2 accepts → all outputs 0, state IDLE, no res_valid.
  - Next start plus 4 exact samples → clean all-zero result.
  - A second window after a valid one clears the previous statistics on start.
